// File: rtl/matmul_ctrl_pkg.sv
// Shared types and constants for the matrix-multiply job controller.
//   state_t : controller FSM states
//   SEL_*   : host memory select encoding carried on h_sel
package matmul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_V0   = 2'd0;
    localparam logic [1:0] SEL_V1   = 2'd1;
    localparam logic [1:0] SEL_V2   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/matmul_port_mux.sv
// Host/kernel port selector for one single-port RAM.
//   rst          : synchronous reset; forces the RAM strobes low while asserted
//   kernel_sel   : 1 = kernel owns the RAM, 0 = host owns it
//   h_en/h_we/h_addr/h_wdata : host access (h_en already includes grant and select)
//   k_en/k_we/k_addr/k_wdata : kernel access
//   m_addr/m_en/m_we/m_wdata : RAM port
module matmul_port_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              rst,
    input  logic              kernel_sel,
    input  logic              h_en,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              k_en,
    input  logic              k_we,
    input  logic [ADDR_W-1:0] k_addr,
    input  logic [DATA_W-1:0] k_wdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_en,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wdata
);

    // Route the owning side to the RAM; strobes are suppressed during reset.
    always_comb begin
        m_addr  = h_addr;
        m_wdata = h_wdata;
        m_en    = 1'b0;
        m_we    = 1'b0;
        if (kernel_sel) begin
            m_addr  = k_addr;
            m_wdata = k_wdata;
        end else begin
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end
        if (rst) begin
            m_en = 1'b0;
            m_we = 1'b0;
        end else if (kernel_sel) begin
            m_en = k_en;
            m_we = k_en & k_we;
        end else begin
            m_en = h_en;
            m_we = h_en & h_we;
        end
    end

endmodule

// File: rtl/matmul_ctrl.sv
// Job controller for a matrix-multiply kernel sharing three single-port RAMs
// (v0, v1 read by the kernel, v2 written by the kernel) with a host port.
//   start_valid/start_ready : job-start handshake (ready only in IDLE)
//   busy/done               : job in progress / one-cycle completion pulse
//   k_tstart                : one-cycle kernel start pulse
//   h_*                     : host request, grant and read return
//   k_*                     : kernel RAM ports, live only in START and RUN
//   mN_*                    : RAM ports, 1-cycle read latency
module matmul_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RUN_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    output logic              busy,
    output logic              done,
    input  logic              h_req,
    input  logic [1:0]        h_sel,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              k_tstart,
    input  logic [ADDR_W-1:0] k_v0_addr,
    input  logic              k_v0_rd_en,
    output logic [DATA_W-1:0] k_v0_rd_data,
    input  logic [ADDR_W-1:0] k_v1_addr,
    input  logic              k_v1_rd_en,
    output logic [DATA_W-1:0] k_v1_rd_data,
    input  logic [ADDR_W-1:0] k_v2_addr,
    input  logic              k_v2_wr_en,
    input  logic [DATA_W-1:0] k_v2_wr_data,
    output logic [ADDR_W-1:0] m0_addr,
    output logic              m0_en,
    output logic              m0_we,
    output logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m0_rdata,
    output logic [ADDR_W-1:0] m1_addr,
    output logic              m1_en,
    output logic              m1_we,
    output logic [DATA_W-1:0] m1_wdata,
    input  logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] m2_addr,
    output logic              m2_en,
    output logic              m2_we,
    output logic [DATA_W-1:0] m2_wdata,
    input  logic [DATA_W-1:0] m2_rdata
);

    localparam int              CNT_W    = $clog2(RUN_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             rvalid_r;
    logic [1:0]       rsel_r;
    logic             kernel_mode_s;
    logic             host_mode_s;

    assign kernel_mode_s = (state_r == ST_START) || (state_r == ST_RUN);
    assign host_mode_s   = (state_r == ST_IDLE)  || (state_r == ST_DONE);

    assign start_ready = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign done        = (state_r == ST_DONE);
    assign k_tstart    = (state_r == ST_START);
    assign h_rvalid    = rvalid_r;

    // Host only owns the RAMs in IDLE/DONE; select 3 addresses nothing.
    assign h_gnt = h_req && host_mode_s && (h_sel != SEL_NONE) && !rst;

    // State, run counter and host read-return tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            rvalid_r <= 1'b0;
            rsel_r   <= SEL_V0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            rvalid_r <= h_gnt && !h_we;
            if (h_gnt) begin
                rsel_r <= h_sel;
            end
        end
    end

    // Next-state logic; the counter is cleared on the way into RUN.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_valid) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_next_s = ST_RUN;
                cnt_next_s   = '0;
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // Host read data follows the select captured with the grant.
    always_comb begin
        h_rdata = '0;
        case (rsel_r)
            SEL_V0:  h_rdata = m0_rdata;
            SEL_V1:  h_rdata = m1_rdata;
            SEL_V2:  h_rdata = m2_rdata;
            default: h_rdata = '0;
        endcase
    end

    // Kernel read data is only presented while the kernel owns the RAMs.
    always_comb begin
        k_v0_rd_data = '0;
        k_v1_rd_data = '0;
        if (kernel_mode_s) begin
            k_v0_rd_data = m0_rdata;
            k_v1_rd_data = m1_rdata;
        end else begin
            k_v0_rd_data = '0;
            k_v1_rd_data = '0;
        end
    end

    matmul_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux_v0 (
        .rst        (rst),
        .kernel_sel (kernel_mode_s),
        .h_en       (h_gnt && (h_sel == SEL_V0)),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .k_en       (k_v0_rd_en),
        .k_we       (1'b0),
        .k_addr     (k_v0_addr),
        .k_wdata    ({DATA_W{1'b0}}),
        .m_addr     (m0_addr),
        .m_en       (m0_en),
        .m_we       (m0_we),
        .m_wdata    (m0_wdata)
    );

    matmul_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux_v1 (
        .rst        (rst),
        .kernel_sel (kernel_mode_s),
        .h_en       (h_gnt && (h_sel == SEL_V1)),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .k_en       (k_v1_rd_en),
        .k_we       (1'b0),
        .k_addr     (k_v1_addr),
        .k_wdata    ({DATA_W{1'b0}}),
        .m_addr     (m1_addr),
        .m_en       (m1_en),
        .m_we       (m1_we),
        .m_wdata    (m1_wdata)
    );

    matmul_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux_v2 (
        .rst        (rst),
        .kernel_sel (kernel_mode_s),
        .h_en       (h_gnt && (h_sel == SEL_V2)),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .k_en       (k_v2_wr_en),
        .k_we       (1'b1),
        .k_addr     (k_v2_addr),
        .k_wdata    (k_v2_wr_data),
        .m_addr     (m2_addr),
        .m_en       (m2_en),
        .m_we       (m2_we),
        .m_wdata    (m2_wdata)
    );

endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl with RUN_CYCLES=16 and behavioural RAMs.
module tb_matmul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid, start_ready, busy, done, k_tstart;
    logic        h_req, h_we, h_gnt, h_rvalid;
    logic [1:0]  h_sel;
    logic [7:0]  h_addr;
    logic [31:0] h_wdata, h_rdata;
    logic [7:0]  k_v0_addr, k_v1_addr, k_v2_addr;
    logic        k_v0_rd_en, k_v1_rd_en, k_v2_wr_en;
    logic [31:0] k_v0_rd_data, k_v1_rd_data, k_v2_wr_data;
    logic [7:0]  m0_addr, m1_addr, m2_addr;
    logic        m0_en, m1_en, m2_en, m0_we, m1_we, m2_we;
    logic [31:0] m0_wdata, m1_wdata, m2_wdata;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] mem2 [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_ctrl #(.ADDR_W(8), .DATA_W(32), .RUN_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .busy(busy), .done(done),
        .h_req(h_req), .h_sel(h_sel), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .k_tstart(k_tstart),
        .k_v0_addr(k_v0_addr), .k_v0_rd_en(k_v0_rd_en), .k_v0_rd_data(k_v0_rd_data),
        .k_v1_addr(k_v1_addr), .k_v1_rd_en(k_v1_rd_en), .k_v1_rd_data(k_v1_rd_data),
        .k_v2_addr(k_v2_addr), .k_v2_wr_en(k_v2_wr_en), .k_v2_wr_data(k_v2_wr_data),
        .m0_addr(m0_addr), .m0_en(m0_en), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_en(m1_en), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m2_addr(m2_addr), .m2_en(m2_en), .m2_we(m2_we), .m2_wdata(m2_wdata), .m2_rdata(m2_rdata)
    );

    // Single-port RAM models with one cycle of read latency.
    always @(posedge clk) begin
        if (m0_en) begin
            if (m0_we) mem0[m0_addr] <= m0_wdata;
            m0_rdata <= mem0[m0_addr];
        end
        if (m1_en) begin
            if (m1_we) mem1[m1_addr] <= m1_wdata;
            m1_rdata <= mem1[m1_addr];
        end
        if (m2_en) begin
            if (m2_we) mem2[m2_addr] <= m2_wdata;
            m2_rdata <= mem2[m2_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        req;
        logic [1:0]  sel;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        kwe;
        logic        gnt;
        logic [2:0]  en;
        logic [2:0]  wen;
        logic        rv;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [9];
    int   done_at;

    initial begin
        // {req, sel, we, addr, wdata, kwe | gnt, en{2,1,0}, we{2,1,0}, rvalid, rdata}
        vecs[0] = '{1'b1, 2'd0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1, 3'b001, 3'b001, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 2'd0, 1'b0, 8'h10, 32'h0,        1'b0, 1'b1, 3'b001, 3'b000, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 2'd1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b1, 3'b010, 3'b010, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 2'd2, 1'b1, 8'h03, 32'hA5A5A5A5, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 2'd1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 32'h12345678};
        vecs[5] = '{1'b1, 2'd2, 1'b0, 8'h03, 32'h0,        1'b0, 1'b1, 3'b100, 3'b000, 1'b1, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 2'd3, 1'b1, 8'h10, 32'h0,        1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 2'd2, 1'b0, 8'h03, 32'h0,        1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 2'd2, 1'b0, 8'h03, 32'h0,        1'b0, 1'b1, 3'b100, 3'b000, 1'b1, 32'hA5A5A5A5};

        rst = 1'b1; start_valid = 1'b0;
        h_req = 1'b0; h_sel = 2'd0; h_we = 1'b0; h_addr = 8'h0; h_wdata = 32'h0;
        k_v0_addr = 8'h10; k_v1_addr = 8'h0; k_v2_addr = 8'h03;
        k_v0_rd_en = 1'b0; k_v1_rd_en = 1'b0; k_v2_wr_en = 1'b0; k_v2_wr_data = 32'h55;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tstart", k_tstart, 1'b0);
        chk("rst_rvalid", h_rvalid, 1'b0);
        chk("rst_ready", start_ready, 1'b1);

        // Host accesses in IDLE driven from the vector table.
        for (int v = 0; v < 9; v++) begin
            next_cycle();
            h_req = vecs[v].req; h_sel = vecs[v].sel; h_we = vecs[v].we;
            h_addr = vecs[v].addr; h_wdata = vecs[v].wdata; k_v2_wr_en = vecs[v].kwe;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", v), h_gnt, vecs[v].gnt);
            chk($sformatf("v%0d_en", v), {m2_en, m1_en, m0_en}, vecs[v].en);
            chk($sformatf("v%0d_we", v), {m2_we, m1_we, m0_we}, vecs[v].wen);
            next_cycle();
            h_req = 1'b0; k_v2_wr_en = 1'b0;
            chk($sformatf("v%0d_rvalid", v), h_rvalid, vecs[v].rv);
            if (vecs[v].rv) chk($sformatf("v%0d_rdata", v), h_rdata, vecs[v].rd);
        end

        // Full job: accept at step 0, START at 1, RUN 2..17, DONE 18, IDLE 19.
        // Host holds a v0 read through the job; kernel writes v2 and reads v0.
        next_cycle();
        for (int i = 0; i <= 19; i++) begin
            start_valid = (i == 0) || (i >= 5 && i <= 10);
            h_req = (i >= 1 && i <= 18); h_sel = 2'd0; h_we = 1'b0; h_addr = 8'h10;
            k_v0_rd_en = (i == 3);
            k_v2_wr_en = (i == 2) || (i == 19);
            @(negedge clk);
            chk($sformatf("job%0d_tstart", i), k_tstart, (i == 1));
            chk($sformatf("job%0d_done", i), done, (i == 18));
            chk($sformatf("job%0d_busy", i), busy, (i >= 1 && i <= 18));
            chk($sformatf("job%0d_ready", i), start_ready, (i == 0 || i == 19));
            chk($sformatf("job%0d_gnt", i), h_gnt, (i == 18));
            chk($sformatf("job%0d_m01we", i), {m1_we, m0_we}, 2'b00);
            chk($sformatf("job%0d_m2we", i), {m2_en, m2_we}, (i == 2) ? 2'b11 : 2'b00);
            chk($sformatf("job%0d_m0en", i), m0_en, (i == 3 || i == 18));
            if (i == 2) begin
                chk("job_m2_addr", m2_addr, 8'h03);
                chk("job_m2_wdata", m2_wdata, 32'h55);
            end
            if (i == 4) chk("job_k_v0_rd_data", k_v0_rd_data, 32'hDEADBEEF);
            if (i == 19) begin
                chk("done_read_rvalid", h_rvalid, 1'b1);
                chk("done_read_rdata", h_rdata, 32'hDEADBEEF);
            end
            next_cycle();
        end
        start_valid = 1'b0; h_req = 1'b0; k_v0_rd_en = 1'b0; k_v2_wr_en = 1'b0;

        // Kernel write from RUN landed in v2.
        h_req = 1'b1; h_sel = 2'd2; h_we = 1'b0; h_addr = 8'h03;
        @(negedge clk);
        chk("v2_read_gnt", h_gnt, 1'b1);
        next_cycle();
        h_req = 1'b0;
        chk("v2_read_rvalid", h_rvalid, 1'b1);
        chk("v2_read_rdata", h_rdata, 32'h55);

        // Reset in RUN cycle 8 (step 9) aborts the job; then a fresh job runs.
        next_cycle();
        for (int i = 0; i <= 11; i++) begin
            start_valid = (i == 0) || (i == 11);
            rst = (i == 9);
            k_v0_rd_en = (i == 9); k_v2_wr_en = (i == 9);
            h_req = (i == 10); h_sel = 2'd0; h_we = 1'b0; h_addr = 8'h10;
            @(negedge clk);
            chk($sformatf("abort%0d_done", i), done, 1'b0);
            if (i == 9) chk("abort_rst_strobes", {m2_we, m2_en, m1_en, m0_en}, 4'b0000);
            if (i == 10) begin
                chk("abort_busy", busy, 1'b0);
                chk("abort_ready", start_ready, 1'b1);
                chk("abort_tstart", k_tstart, 1'b0);
                chk("abort_rvalid", h_rvalid, 1'b0);
                chk("abort_host_gnt", h_gnt, 1'b1);
            end
            if (i == 11) begin
                chk("abort_read_rvalid", h_rvalid, 1'b1);
                chk("abort_read_rdata", h_rdata, 32'hDEADBEEF);
                chk("restart_ready", start_ready, 1'b1);
            end
            next_cycle();
        end
        start_valid = 1'b0; rst = 1'b0; h_req = 1'b0; k_v0_rd_en = 1'b0; k_v2_wr_en = 1'b0;

        // Restarted job: bounded wait for done, expected 18 cycles after accept.
        done_at = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) chk("restart_tstart", k_tstart, 1'b1);
            if (done && done_at == 0) done_at = k;
            next_cycle();
        end
        chk("restart_done_cycle", done_at, 18);
        @(negedge clk);
        chk("restart_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
